array_reduce: RTL

ARRAY_REDUCE -- requirements
Module: array_reduce

---
 rtl/array_reduce.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/array_reduce.sv
// rtl/array_reduce.sv - streaming sum/min/max reduction over a length-prefixed array
//
// Ports:
//   clk, reset_n           clock, synchronous active-low reset
//   start, len, mode       request a reduction of len elements (mode 00/11 sum, 01 min, 10 max)
//   abort                  cancel a reduction in progress
//   in_valid, in_data      element stream; in_ready is high only while busy
//   result, count          reduction result (zero-extended for min/max) and accepted element count
//   busy, done, overflow   running flag, end-of-reduction pulse, sticky sum carry-out flag

module array_reduce #(
    parameter int DATA_W = 32,
    parameter int LEN_W  = 9,
    parameter int ACC_W  = 41
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [LEN_W-1:0]  len,
    input  logic [1:0]        mode,
    input  logic              abort,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic [ACC_W-1:0]  result,
    output logic [LEN_W-1:0]  count,
    output logic              busy,
    output logic              done,
    output logic              overflow
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [1:0] MODE_MIN = 2'b01;
    localparam logic [1:0] MODE_MAX = 2'b10;

    state_t             state_q, state_d;
    logic [ACC_W-1:0]   result_q, result_d;
    logic [LEN_W-1:0]   count_q, count_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic [1:0]         mode_q, mode_d;
    logic               ovf_q, ovf_d;

    // One spare bit on the adder captures the carry out of the accumulator.
    logic [ACC_W:0]     data_ext;
    logic [ACC_W:0]     sum_full;
    logic [ACC_W-1:0]   data_acc;
    logic [LEN_W-1:0]   count_inc;

    assign data_ext  = {{(ACC_W + 1 - DATA_W){1'b0}}, in_data};
    assign data_acc  = data_ext[ACC_W-1:0];
    assign sum_full  = {1'b0, result_q} + data_ext;
    assign count_inc = count_q + 1'b1;

    always_comb begin
        state_d  = state_q;
        result_d = result_q;
        count_d  = count_q;
        len_d    = len_q;
        mode_d   = mode_q;
        ovf_d    = ovf_q;

        case (state_q)
            ST_IDLE: begin
                // start wins over a simultaneous abort; abort has no meaning here.
                if (start) begin
                    len_d    = len;
                    mode_d   = mode;
                    result_d = '0;
                    count_d  = '0;
                    ovf_d    = 1'b0;
                    state_d  = (len == '0) ? ST_DONE : ST_RUN;
                end
            end
            ST_RUN: begin
                if (abort) begin
                    // Any beat in the same cycle is dropped.
                    result_d = '0;
                    count_d  = '0;
                    state_d  = ST_IDLE;
                end else if (in_valid) begin
                    count_d = count_inc;
                    if (mode_q == MODE_MIN || mode_q == MODE_MAX) begin
                        // First beat seeds the running extreme; ties keep the old value.
                        if (count_q == '0) begin
                            result_d = data_acc;
                        end else if (mode_q == MODE_MIN && data_acc < result_q) begin
                            result_d = data_acc;
                        end else if (mode_q == MODE_MAX && data_acc > result_q) begin
                            result_d = data_acc;
                        end
                    end else begin
                        result_d = sum_full[ACC_W-1:0];
                        if (sum_full[ACC_W]) begin
                            ovf_d = 1'b1;
                        end
                    end
                    if (count_inc == len_q) begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q  <= ST_IDLE;
            result_q <= '0;
            count_q  <= '0;
            len_q    <= '0;
            mode_q   <= '0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
            count_q  <= count_d;
            len_q    <= len_d;
            mode_q   <= mode_d;
            ovf_q    <= ovf_d;
        end
    end

    assign in_ready = (state_q == ST_RUN);
    assign busy     = (state_q == ST_RUN);
    assign done     = (state_q == ST_DONE);
    assign result   = result_q;
    assign count    = count_q;
    assign overflow = ovf_q;

endmodule
